address_demapper: RTL and testbench
===================================

Name: address_demapper

Overview:
- Inverse of the NASTI-to-SDRAM address mapper. Takes {rank, bank, row, column} coordinates plus a tag from the DFI side and rebuilds the byte-aligned NASTI address.
- Used for read-return matching, ECC error logging and refresh/scrub reporting.
- Two-stage registered pipeline with valid/ready handshakes on both ends. Flags coordinates that are illegal for the current geometry.

Parameters:
- C_NASTI_ADDR_WIDTH, 32, width of reconstructed NASTI address.
- C_DFI_CS_WIDTH, 2, number of one-hot chip selects (ranks).
- C_DFI_DATA_WIDTH, 64, DFI data width. OFFSET_BITS = $clog2(C_DFI_DATA_WIDTH/16).
- C_ID_WIDTH, 4, opaque tag carried alongside each request.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- r_width, input, row_widths, row geometry (r11..r15).
- c_width, input, col_widths, column geometry (c9..c11).
- bor, input, 1, field order: 1 = bank at msb, 0 = rank at msb.
- in_valid, input, 1, request valid.
- in_ready, output, 1, request accepted when in_valid && in_ready.
- in_rank, input, C_DFI_CS_WIDTH, one-hot rank.
- in_bank, input, 3, bank.
- in_row, input, 16, row.
- in_column, input, 12, column.
- in_id, input, C_ID_WIDTH, tag.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accept.
- out_addr, output, C_NASTI_ADDR_WIDTH, reconstructed address.
- out_id, output, C_ID_WIDTH, tag of result.
- out_err, output, 1, illegal coordinates for this result.

Behaviour:
- Field widths:
  - CB (column bits) = 10 / 11 / 12 for c9 / c10 / c11.
  - RB (row bits) = 12 / 13 / 14 / 15 / 16 for r11 / r12 / r13 / r14 / r15.
  - Bank = 3 bits.
  - KB (rank-index bits) = $clog2(C_DFI_CS_WIDTH), 0 if C_DFI_CS_WIDTH = 1.
- Address layout, LSB first:
  - OFFSET_BITS zero bits, then column[CB-1:0], then row[RB-1:0].
  - bor = 0: then bank, then rank index.
  - bor = 1: then rank index, then bank.
  - All bits above the top field are 0.
- Rank index = position of the single set bit of in_rank.
- Stage 1 (S1), on handshake:
  - Register the coordinates, id and rank index.
  - Compute err1 = (column bits at or above CB nonzero) OR (row bits at or above RB nonzero) OR (in_rank not exactly one-hot).
  - When in_rank is not one-hot, the rank index is 0.
- Stage 2 (S2): register out_addr, out_id and out_err.
  - out_err = err1 OR (any nonzero field bit would land at or above C_NASTI_ADDR_WIDTH). Such bits are dropped.
  - Out-of-range column/row bits are masked off, never OR'd into the address.
- Geometry (r_width, c_width, bor):
  - Sampled in S2 when the S1-to-S2 move happens.
  - Software changes it only while the block is idle; behaviour with traffic in flight is undefined.
- Latency: accept at cycle N gives out_valid at cycle N+2 when not stalled. Throughput is 1 per cycle.
- Handshake:
  - out_* hold stable while out_valid && !out_ready.
  - S2 loads when it is empty or out_ready = 1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || S1 advancing. This is combinational from out_ready; no skid buffer is required.
  - Simultaneous input accept and output drain with both stages full is lossless and sustains 1 per cycle.
- Ordering: strict FIFO order, no reordering, ids are passed through untouched.
- Reset (rst = 1 at a clk edge):
  - s1_valid = 0, out_valid = 0, out_addr = 0, out_id = 0, out_err = 0.
  - in_ready is 1 on the first cycle after reset.
  - In-flight items are discarded.
  - rst overrides a same-cycle handshake.
- Full pipeline with out_ready = 0: in_ready = 0, both stages hold and no data changes.

Test Plan:
- Bit layout, bor = 0: default params (OFFSET_BITS = 2, KB = 1), c10, r13, col = 0x123, row = 0x0ABC, bank = 5, rank = 2'b10, id = 3 -> out_addr = 0x6957848C, out_id = 3, out_err = 0, two cycles after accept.
- Bit layout, bor = 1: same coordinates -> out_addr = 0x5957848C.
- Illegal column: c10, col = 0x923 (bit 11 set), rest as above -> out_addr = 0x6957848C (bit masked), out_err = 1.
- Illegal rank: rank = 2'b11 -> out_err = 1 and rank field 0. With the first scenario's coordinates, out_addr = 0x2957848C.
- Back-to-back stream: 8 requests, id 0..7, with out_ready toggling 1,0,0,1,... -> all 8 emerge in order with no loss and no duplication. in_ready drops only when both stages are full and out_ready = 0.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid = 0, in_ready = 1, outputs zero. A subsequent request completes with latency 2.

Source files
------------

// File: rtl/address_demapper.sv
// Rebuilds a byte-aligned NASTI address from DFI {rank, bank, row, column}
// coordinates. Two registered stages with valid/ready on both sides; each
// result is flagged when its coordinates are illegal for the current geometry.
//   r_width: 0..4 = r11..r15 (codes above 4 decode as r15)
//   c_width: 0..2 = c9..c11  (code 3 decodes as c11)
module address_demapper #(
    parameter int unsigned C_NASTI_ADDR_WIDTH = 32,
    parameter int unsigned C_DFI_CS_WIDTH     = 2,
    parameter int unsigned C_DFI_DATA_WIDTH   = 64,
    parameter int unsigned C_ID_WIDTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    r_width,
    input  logic [1:0]                    c_width,
    input  logic                          bor,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [C_DFI_CS_WIDTH-1:0]     in_rank,
    input  logic [2:0]                    in_bank,
    input  logic [15:0]                   in_row,
    input  logic [11:0]                   in_column,
    input  logic [C_ID_WIDTH-1:0]         in_id,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [C_NASTI_ADDR_WIDTH-1:0] out_addr,
    output logic [C_ID_WIDTH-1:0]         out_id,
    output logic                          out_err
);

    localparam int unsigned OFFSET_BITS = $clog2(C_DFI_DATA_WIDTH / 16);
    localparam int unsigned KB          = (C_DFI_CS_WIDTH > 1) ? $clog2(C_DFI_CS_WIDTH) : 0;
    localparam int unsigned RANK_W      = (KB > 0) ? KB : 1;
    // Wide enough for every field at its highest possible position plus the
    // full output width, so overflow bits can be detected before truncation.
    localparam int unsigned WIDE_W      = C_NASTI_ADDR_WIDTH + OFFSET_BITS + 12 + 16 + 3 + RANK_W;
    localparam int unsigned SH_W        = $clog2(WIDE_W + 1);

    // Geometry decode
    logic [SH_W-1:0] cb;
    logic [SH_W-1:0] rb;
    logic [11:0]     col_mask;
    logic [15:0]     row_mask;

    // Rank decode
    logic              rank_onehot;
    logic [RANK_W-1:0] rank_pos;

    // Stage 1 registers
    logic                  s1_valid;
    logic [2:0]            s1_bank;
    logic [15:0]           s1_row;
    logic [11:0]           s1_column;
    logic [C_ID_WIDTH-1:0] s1_id;
    logic [RANK_W-1:0]     s1_rank_idx;
    logic                  s1_err;

    // Handshake and stage-2 datapath
    logic              in_fire;
    logic              s2_load;
    logic              in_err_c;
    logic [11:0]       col_m;
    logic [15:0]       row_m;
    logic [SH_W-1:0]   row_sh;
    logic [SH_W-1:0]   top_sh;
    logic [WIDE_W-1:0] wide;
    logic              s2_err_c;

    // Column/row widths and masks for the current geometry
    always_comb begin
        cb       = SH_W'(12);
        col_mask = 12'hFFF;
        case (c_width)
            2'd0:    begin cb = SH_W'(10); col_mask = 12'h3FF; end
            2'd1:    begin cb = SH_W'(11); col_mask = 12'h7FF; end
            default: ;
        endcase
        rb       = SH_W'(16);
        row_mask = 16'hFFFF;
        case (r_width)
            3'd0:    begin rb = SH_W'(12); row_mask = 16'h0FFF; end
            3'd1:    begin rb = SH_W'(13); row_mask = 16'h1FFF; end
            3'd2:    begin rb = SH_W'(14); row_mask = 16'h3FFF; end
            3'd3:    begin rb = SH_W'(15); row_mask = 16'h7FFF; end
            default: ;
        endcase
    end

    // One-hot check and set-bit position of the incoming chip select
    always_comb begin
        rank_onehot = (in_rank != '0) &&
                      ((in_rank & (in_rank - C_DFI_CS_WIDTH'(1))) == '0);
        rank_pos    = '0;
        for (int i = 0; i < C_DFI_CS_WIDTH; i++) begin
            if (in_rank[i]) begin
                rank_pos = RANK_W'(i);
            end
        end
    end

    // Handshake: S2 loads when empty or draining, S1 frees up when S2 loads
    always_comb begin
        s2_load  = s1_valid && (!out_valid || out_ready);
        in_ready = !s1_valid || s2_load;
        in_fire  = in_valid && in_ready;
        in_err_c = (|(in_column & ~col_mask)) || (|(in_row & ~row_mask)) || !rank_onehot;
    end

    // Stage 1 valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 1 payload capture; qualified by s1_valid so no reset needed
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_bank     <= in_bank;
            s1_row      <= in_row;
            s1_column   <= in_column;
            s1_id       <= in_id;
            s1_rank_idx <= rank_onehot ? rank_pos : '0;
            s1_err      <= in_err_c;
        end
    end

    // Assemble the address in a wide vector; anything above the output width is an error
    always_comb begin
        col_m  = s1_column & col_mask;
        row_m  = s1_row & row_mask;
        row_sh = SH_W'(OFFSET_BITS) + cb;
        top_sh = row_sh + rb;
        wide   = (WIDE_W'(col_m) << OFFSET_BITS) | (WIDE_W'(row_m) << row_sh);
        if (bor) begin
            wide = wide | (WIDE_W'(s1_rank_idx) << top_sh)
                        | (WIDE_W'(s1_bank) << (top_sh + SH_W'(KB)));
        end else begin
            wide = wide | (WIDE_W'(s1_bank) << top_sh)
                        | (WIDE_W'(s1_rank_idx) << (top_sh + SH_W'(3)));
        end
        s2_err_c = s1_err || (|wide[WIDE_W-1:C_NASTI_ADDR_WIDTH]);
    end

    // Stage 2 output register; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_id    <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            out_addr  <= wide[C_NASTI_ADDR_WIDTH-1:0];
            out_id    <= s1_id;
            out_err   <= s2_err_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_address_demapper.sv
// Bench for address_demapper: directed layout/boundary vectors, stall and
// reset scenarios, and randomized streams scored against an arithmetic model.
`timescale 1ns/1ps
module tb_address_demapper;

    localparam int unsigned AW = 32;
    localparam int unsigned CS = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned IW = 4;
    localparam longint unsigned OFF_MUL  = 64'(DW / 16);
    localparam longint unsigned RANK_MUL = 64'(1) << $clog2(CS);

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    r_width;
    logic [1:0]    c_width;
    logic          bor;
    logic          in_valid;
    logic          in_ready;
    logic [CS-1:0] in_rank;
    logic [2:0]    in_bank;
    logic [15:0]   in_row;
    logic [11:0]   in_column;
    logic [IW-1:0] in_id;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [IW-1:0] out_id;
    logic          out_err;

    address_demapper #(
        .C_NASTI_ADDR_WIDTH (AW),
        .C_DFI_CS_WIDTH     (CS),
        .C_DFI_DATA_WIDTH   (DW),
        .C_ID_WIDTH         (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r_width   (r_width),
        .c_width   (c_width),
        .bor       (bor),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rank   (in_rank),
        .in_bank   (in_bank),
        .in_row    (in_row),
        .in_column (in_column),
        .in_id     (in_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_id    (out_id),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_out  = 0;

    // Single comparison point for the whole bench
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference: place each field by multiplying with the size of the fields below it
    function automatic exp_t model(input int unsigned rw, input int unsigned cw, input logic b,
                                   input logic [CS-1:0] rank, input logic [2:0] bank,
                                   input logic [15:0] row, input logic [11:0] col,
                                   input logic [IW-1:0] id);
        exp_t e;
        int unsigned cbits, rbits, ones;
        longint unsigned a, fld, rk, colw, roww;
        cbits = (cw >= 2) ? 12 : 10 + cw;
        rbits = (rw >= 4) ? 16 : 12 + rw;
        colw  = 64'(1) << cbits;
        roww  = 64'(1) << rbits;
        ones  = $countones(rank);
        rk    = 0;
        if (ones == 1) begin
            for (int i = 0; i < CS; i++) if (rank[i]) rk = 64'(i);
        end
        e.err = (64'(col) >= colw) || (64'(row) >= roww) || (ones != 1);
        a     = (64'(col) % colw) * OFF_MUL;
        a     = a + (64'(row) % roww) * OFF_MUL * colw;
        fld   = OFF_MUL * colw * roww;
        if (!b) a = a + 64'(bank) * fld + rk * fld * 8;
        else    a = a + rk * fld + 64'(bank) * fld * RANK_MUL;
        if (a >= (64'(1) << AW)) e.err = 1'b1;
        e.addr = a[AW-1:0];
        e.id   = id;
        return e;
    endfunction

    // Scoreboard: checks in_ready against pipeline occupancy, then scores outputs, then records accepts
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            check_eq("in_ready_vs_occupancy", 64'(in_ready),
                     64'(!(sb.size() == 2 && !out_ready)));
            if (sb.size() == 0) check_eq("out_valid_when_empty", 64'(out_valid), 64'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("sb_addr", 64'(out_addr), 64'(mon_e.addr));
                    check_eq("sb_id",   64'(out_id),   64'(mon_e.id));
                    check_eq("sb_err",  64'(out_err),  64'(mon_e.err));
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(int'(r_width), int'(c_width), bor, in_rank, in_bank,
                                   in_row, in_column, in_id));
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_geom(input logic [2:0] rw, input logic [1:0] cw, input logic b);
        r_width = rw;
        c_width = cw;
        bor     = b;
        tick();
    endtask

    // Directed request on an idle pipeline: checks two-cycle latency and the result
    task automatic send_one(input string tag, input logic [11:0] col, input logic [15:0] row,
                            input logic [2:0] bank, input logic [CS-1:0] rank,
                            input logic [IW-1:0] id, input logic [AW-1:0] exp_addr,
                            input logic exp_err);
        in_column = col;
        in_row    = row;
        in_bank   = bank;
        in_rank   = rank;
        in_id     = id;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_latency1"}, 64'(out_valid), 64'd0);
        tick();
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, "_addr"},  64'(out_addr),  64'(exp_addr));
        check_eq({tag, "_id"},    64'(out_id),    64'(id));
        check_eq({tag, "_err"},   64'(out_err),   64'(exp_err));
    endtask

    // Random coordinates, mostly legal for the current geometry
    task automatic rand_req(input int unsigned idv);
        int unsigned cbits, rbits, r;
        cbits = (c_width >= 2'd2) ? 12 : 10 + int'(c_width);
        rbits = (r_width >= 3'd4) ? 16 : 12 + int'(r_width);
        in_column = 12'($urandom);
        if ($urandom_range(3) != 0) in_column = in_column & 12'((1 << cbits) - 1);
        in_row = 16'($urandom);
        if ($urandom_range(3) != 0) in_row = in_row & 16'((1 << rbits) - 1);
        in_bank = 3'($urandom);
        r = $urandom_range(9);
        if (r < 8)       in_rank = CS'(1) << (r % CS);
        else if (r == 8) in_rank = '0;
        else             in_rank = '1;
        in_id = IW'(idv);
    endtask

    // Stream n requests; out_ready is random (pr %) or the 1,0,0 pattern
    task automatic stream(input string tag, input int unsigned n, input int unsigned pv,
                          input int unsigned pr, input bit pattern);
        int unsigned sent, k, base;
        bit fire;
        sent = 0;
        k    = 0;
        base = n_out;
        in_valid = 1'b0;
        while ((n_out - base) < n && k < n * 20 + 50) begin
            out_ready = pattern ? (k % 3 == 0) : ($urandom_range(99) < pr);
            if (!in_valid && sent < n && $urandom_range(99) < pv) begin
                rand_req(sent);
                in_valid = 1'b1;
            end
            @(negedge clk);
            fire = in_valid && in_ready;
            tick();
            if (fire) begin
                sent++;
                in_valid = 1'b0;
            end
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq({tag, "_count"}, 64'(n_out - base), 64'(n));
    endtask

    initial begin
        int unsigned sent;
        bit fire;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        r_width = 3'd2; c_width = 2'd1; bor = 1'b0;
        in_rank = '0; in_bank = '0; in_row = '0; in_column = '0; in_id = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_out_addr",  64'(out_addr),  64'd0);
        check_eq("rst_out_id",    64'(out_id),    64'd0);
        check_eq("rst_out_err",   64'(out_err),   64'd0);

        // Layout vectors at c10 / r13
        send_one("bor0",     12'h123, 16'h0ABC, 3'd5, 2'b10, 4'd3, 32'h6957848C, 1'b0);
        set_geom(3'd2, 2'd1, 1'b1);
        send_one("bor1",     12'h123, 16'h0ABC, 3'd5, 2'b10, 4'd3, 32'h5957848C, 1'b0);
        set_geom(3'd2, 2'd1, 1'b0);
        send_one("bad_col",  12'h923, 16'h0ABC, 3'd5, 2'b10, 4'd9, 32'h6957848C, 1'b1);
        send_one("bad_row",  12'h123, 16'hCABC, 3'd5, 2'b10, 4'd6, 32'h6957848C, 1'b1);
        send_one("rank11",   12'h123, 16'h0ABC, 3'd5, 2'b11, 4'd4, 32'h2957848C, 1'b1);
        send_one("rank00",   12'h123, 16'h0ABC, 3'd5, 2'b00, 4'd5, 32'h2957848C, 1'b1);
        // Widest geometry: fields reach past bit 31
        set_geom(3'd4, 2'd2, 1'b0);
        send_one("ovf_bor0", 12'hFFF, 16'hFFFF, 3'd7, 2'b10, 4'd7, 32'hFFFFFFFC, 1'b1);
        send_one("fit_bor0", 12'hFFF, 16'hFFFF, 3'd1, 2'b01, 4'd8, 32'h7FFFFFFC, 1'b0);
        set_geom(3'd4, 2'd2, 1'b1);
        send_one("fit_bor1", 12'hFFF, 16'hFFFF, 3'd1, 2'b10, 4'hA, 32'hFFFFFFFC, 1'b0);
        send_one("ovf_bor1", 12'hFFF, 16'hFFFF, 3'd2, 2'b10, 4'hC, 32'h7FFFFFFC, 1'b1);
        // Narrowest geometry
        set_geom(3'd0, 2'd0, 1'b0);
        send_one("narrow",   12'h3FF, 16'h0FFF, 3'd0, 2'b01, 4'hB, 32'h00FFFFFC, 1'b0);
        tick();

        // Eight back-to-back requests with out_ready 1,0,0,...
        set_geom(3'd2, 2'd1, 1'b0);
        stream("stream8", 8, 100, 0, 1'b1);
        tick();

        // Full rate with no backpressure: one accept per cycle
        sent = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rand_req(k);
            in_valid = 1'b1;
            @(negedge clk);
            fire = in_valid && in_ready;
            tick();
            if (fire) sent++;
        end
        in_valid = 1'b0;
        check_eq("full_rate_accepts", 64'(sent), 64'd16);
        repeat (3) tick();

        // Random streams over legal geometries
        for (int b = 0; b < 6; b++) begin
            set_geom(3'($urandom_range(4)), 2'($urandom_range(2)), 1'($urandom));
            stream("rand", 40, 70, 60, 1'b0);
            tick();
        end
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        // Fill both stages with the output stalled
        set_geom(3'd2, 2'd1, 1'b0);
        out_ready = 1'b0;
        rand_req(1); in_valid = 1'b1;
        tick();
        rand_req(2);
        tick();
        rand_req(3);
        for (int k = 0; k < 3; k++) begin
            check_eq("stall_in_ready",  64'(in_ready),  64'd0);
            check_eq("stall_out_valid", 64'(out_valid), 64'd1);
            if (sb.size() > 0) check_eq("stall_hold_addr", 64'(out_addr), 64'(sb[0].addr));
            if (sb.size() > 0) check_eq("stall_hold_id",   64'(out_id),   64'(sb[0].id));
            tick();
        end

        // Reset while full, with a handshake offered on both sides in that cycle
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("mid_rst_out_addr",  64'(out_addr),  64'd0);
        check_eq("mid_rst_out_id",    64'(out_id),    64'd0);
        check_eq("mid_rst_out_err",   64'(out_err),   64'd0);
        send_one("post_rst", 12'h123, 16'h0ABC, 3'd5, 2'b10, 4'd3, 32'h6957848C, 1'b0);
        repeat (3) tick();
        check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
